// File: rtl/imem_responder.sv
// Instruction memory with one outstanding fetch; responses appear exactly LATENCY cycles after acceptance.
// A pending response holds until resp_ready or flush; program-load writes share the array.
module imem_responder #(
  parameter int BIN_DIG = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [BIN_DIG-1:0] req_addr,
  input  logic               flush,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [BIN_DIG-1:0] resp_pc,
  output logic [BIN_DIG-1:0] resp_inst,
  output logic               resp_fault,
  input  logic               prog_we,
  input  logic [BIN_DIG-1:0] prog_addr,
  input  logic [BIN_DIG-1:0] prog_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [BIN_DIG-1:0] NOP = BIN_DIG'(32'h13);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [BIN_DIG-1:0] pc_q, pc_d;
  logic [BIN_DIG-1:0] inst_q, inst_d;
  logic               fault_q, fault_d;

  logic [BIN_DIG-1:0] mem_q [DEPTH];

  logic               accept;
  logic               sample;
  logic               rd_fault;
  logic [BIN_DIG-1:0] rd_addr;
  logic [BIN_DIG-1:0] rd_word;
  logic [AW-1:0]      rd_idx;
  logic [AW-1:0]      wr_idx;

  function automatic logic addr_ok(input logic [BIN_DIG-1:0] a);
    return (a[1:0] == 2'b00) && ({2'b00, a[BIN_DIG-1:2]} < BIN_DIG'(DEPTH));
  endfunction

  assign req_ready  = RST && (state_q == IDLE) && !flush;
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state_q == RESP);
  assign resp_pc    = pc_q;
  assign resp_inst  = inst_q;
  assign resp_fault = fault_q;

  // With LATENCY=1 the read happens on the acceptance edge, so address comes straight from the request.
  assign rd_addr  = (state_q == IDLE) ? req_addr : pc_q;
  assign rd_idx   = rd_addr[AW+1:2];
  assign rd_fault = !addr_ok(rd_addr);
  assign rd_word  = mem_q[rd_idx];
  assign wr_idx   = prog_addr[AW+1:2];

  // The counter reaching zero and the memory sample coincide on the same edge.
  assign sample = (accept && (LATENCY == 1)) ||
                  ((state_q == WAIT) && !flush && (cnt_q == 4'd1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    fault_d = fault_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          pc_d = req_addr;
          if (LATENCY == 1) begin
            state_d = RESP;
            cnt_d   = 4'd0;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (flush || resp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    if (sample) begin
      inst_d  = rd_fault ? NOP : rd_word;
      fault_d = rd_fault;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      pc_q    <= '0;
      inst_q  <= NOP;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      fault_q <= fault_d;
    end
  end

  // Array is deliberately outside reset so a loaded program survives it.
  always_ff @(posedge CLK) begin
    if (prog_we && addr_ok(prog_addr)) begin
      mem_q[wr_idx] <= prog_data;
    end
  end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter BIN_DIG, default 32 (from defs); data and address width.
REQ-002 Parameter DEPTH, default 1024; number of BIN_DIG-bit instruction words.
REQ-003 Parameter LATENCY, default 2, legal range 1..15; cycles from request acceptance to resp_valid.
REQ-004 CLK  input  1  clock, all state updates on posedge.
REQ-005 RST  input  1  reset, asynchronous, active-low.
REQ-006 req_valid  input  1  fetch presents a request.
REQ-007 req_ready  output  1  responder accepts a request this cycle.
REQ-008 req_addr  input  BIN_DIG  byte address (pc) of the requested instruction.
REQ-009 flush  input  1  control hazard (branch | jamp); kill any outstanding request.
REQ-010 resp_valid  output  1  response held on resp_pc/resp_inst/resp_fault.
REQ-011 resp_ready  input  1  fetch consumes the response.
REQ-012 resp_pc  output  BIN_DIG  req_addr of the request being answered.
REQ-013 resp_inst  output  BIN_DIG  instruction word.
REQ-014 resp_fault  output  1  request misaligned or out of range.
REQ-015 prog_we  input  1  program-load write enable.
REQ-016 prog_addr  input  BIN_DIG  byte address of program-load write.
REQ-017 prog_data  input  BIN_DIG  program-load write data.

Function
REQ-018 Storage SHALL be DEPTH words; word index = addr[BIN_DIG-1:2].
REQ-019 FSM states SHALL be IDLE, WAIT, RESP; one outstanding request maximum.
REQ-020 req_ready SHALL be 1 only in IDLE with flush=0; acceptance = req_valid & req_ready at a posedge.
REQ-021 On acceptance SHALL latch req_addr into resp_pc, load latency counter with LATENCY-1, enter WAIT (LATENCY=1: enter RESP directly).
REQ-022 In WAIT the counter SHALL decrement each cycle; at counter=0 SHALL sample memory and enter RESP.
REQ-023 Acceptance at edge T SHALL yield resp_valid=1 in the cycle following edge T+LATENCY-1 (exactly LATENCY cycles later).
REQ-024 In RESP resp_valid SHALL be 1 and resp_pc/resp_inst/resp_fault SHALL stay stable until resp_valid & resp_ready, then return to IDLE.
REQ-025 No new request SHALL be accepted in the handshake cycle; back-to-back throughput is one per LATENCY+1 cycles.
REQ-026 Fault: addr[1:0]!=0 or word index>=DEPTH SHALL give resp_fault=1, resp_inst=32'h13 (NOP), same latency.
REQ-027 flush=1 in WAIT or RESP SHALL return to IDLE at the next edge and discard the response; resp_valid 0 from that edge.
REQ-028 flush=1 in IDLE SHALL force req_ready=0; no acceptance that cycle.
REQ-029 flush and resp_ready both 1 in RESP SHALL be treated as flush (no other side effect differs).
REQ-030 prog_we SHALL write prog_data to word prog_addr[BIN_DIG-1:2] at the edge; out-of-range or misaligned writes ignored.
REQ-031 prog write and memory sample to the same word at the same edge SHALL return the old data.
REQ-032 Memory contents SHALL not be cleared by reset.

Reset
REQ-033 RST=0 SHALL immediately force: state IDLE, counter 0, resp_valid 0, resp_pc 0, resp_inst 32'h13, resp_fault 0; req_ready 0 while RST=0.
REQ-034 RST asserted mid-WAIT/RESP SHALL drop the request; after RST release the first request behaves per REQ-021..023.

Verification
REQ-035 Load word 0x4 := 0x00500093; LATENCY=2; req 0x4 accepted at edge T -> resp_valid at T+2, resp_pc 0x4, resp_inst 0x00500093, fault 0.
REQ-036 Response with resp_ready held 0 for 5 cycles -> outputs stable 5 cycles, req_ready 0; resp_ready=1 -> IDLE next edge, req_ready 1.
REQ-037 Req 0x6 and req DEPTH*4 -> resp_fault 1, resp_inst 32'h13, latency unchanged.
REQ-038 flush one cycle after acceptance -> no resp_valid ever for that request; flush in IDLE with req_valid=1 -> req_ready 0, no acceptance.
REQ-039 prog write 0xDEADBEEF to word 0x8 on the sample edge of a pending read of 0x8 -> old data returned; next read -> 0xDEADBEEF.
REQ-040 RST low mid-WAIT -> resp_valid 0, resp_inst 32'h13 asynchronously; after release, a new request completes in LATENCY cycles.
